// File: rtl/kianv_sc_seq_pkg.sv
// Shared types and constants for the kianv single-port memory sequencer.
package kianv_sc_seq_pkg;

    typedef enum logic [2:0] {
        RST,
        FETCH,
        DATA,
        EXEC,
        HALT,
        ERROR
    } SeqState_t;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Bus is word addressed; byte lane selection is carried by the strobes.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & 32'hffff_fffc;
    endfunction

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/kianv_sc_mem_sequencer_if.sv
// Ready/valid memory bus between the sequencer (master) and SoC memory (slave).
interface kianv_sc_mem_sequencer_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/kianv_sc_mem_watchdog.sv
// Per-transaction wait counter; flags expiry on the TIMEOUT_CYCLES-th wait cycle.
// Instantiated only when KIANV_SC_MEM_TIMEOUT_EN is defined.
module kianv_sc_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic ready,
    output logic expire
);

    logic [31:0] cnt_q, cnt_d;
    logic        waiting;

    assign waiting = valid && !ready;
    assign expire  = waiting && ((cnt_q + 32'd1) >= TIMEOUT_CYCLES);

    // Any idle or accepted cycle clears, so each new phase starts from zero.
    always_comb begin
        cnt_d = 32'd0;
        if (waiting) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kianv_sc_mem_sequencer.sv
// Fetch / data / exec sequencer letting the single-cycle rv32i core share one memory port.
// Optional bus timeout enabled by defining KIANV_SC_MEM_TIMEOUT_EN.
module kianv_sc_mem_sequencer
    import kianv_sc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,

    output logic                            core_ce,
    input  logic [31:0]                     core_pc,
    input  logic [31:0]                     core_alu_result,
    input  logic [31:0]                     core_write_data,
    input  logic [3:0]                      core_write_mask,
    output logic [31:0]                     core_instr,
    output logic [31:0]                     core_read_data,

    kianv_sc_mem_sequencer_if.master        mem,

    input  logic                            halt_req,
    output logic                            halted,
    output logic                            bus_error
);

    SeqState_t   state_q, state_d;
    logic [31:0] instr_q, rdata_q;
    logic        is_store;
    logic        timeout;
    logic        in_error;

    // RESET_ADDR is consumed by the integrating top, not here.
    logic unused_params;
    assign unused_params = ^{RESET_ADDR, TIMEOUT_CYCLES};

    assign is_store = (instr_q[6:0] == OP_STORE);

`ifdef KIANV_SC_MEM_TIMEOUT_EN
    kianv_sc_mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .valid  (mem.mem_valid),
        .ready  (mem.mem_ready),
        .expire (timeout)
    );
    assign bus_error = in_error;
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem.mem_valid = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        mem.mem_wstrb = 4'd0;
        core_ce       = 1'b0;
        halted        = 1'b0;
        in_error      = 1'b0;

        unique case (state_q)
            RST: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem.mem_valid = 1'b1;
                mem.mem_addr  = word_addr(core_pc);
                if (mem.mem_ready) begin
                    state_d = is_mem_op(mem.mem_rdata[6:0]) ? DATA : EXEC;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            DATA: begin
                mem.mem_valid = 1'b1;
                mem.mem_addr  = word_addr(core_alu_result);
                mem.mem_wdata = core_write_data;
                mem.mem_wstrb = is_store ? core_write_mask : 4'd0;
                if (mem.mem_ready) begin
                    state_d = EXEC;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            EXEC: begin
                core_ce = 1'b1;
                state_d = halt_req ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            ERROR: begin
                in_error = 1'b1;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    // Reset has priority over a coincident mem_ready, so nothing is latched then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST;
            instr_q <= NOP_INSTR;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && mem.mem_ready) begin
                instr_q <= mem.mem_rdata;
            end
            if (state_q == DATA && mem.mem_ready && !is_store) begin
                rdata_q <= mem.mem_rdata;
            end
        end
    end

    assign core_instr     = instr_q;
    assign core_read_data = rdata_q;

endmodule
